// File: rtl/dma_mc.sv
// Purpose : N-channel memory-to-memory DMA with round-robin arbitration and per-channel end-of-process.
// Latency : 3 cycles per word (RD, LAT, WR) plus ARB/DONE overhead; eop_ pulses one cycle in DONE.
// Backpressure: takes the bus only when cpu_breq_ is high in IDLE; a burst is never preempted.
//
// Ports:
//   clk, reset            - system clock, asynchronous active-high reset
//   cpu_breq_/cpu_bgrt_   - processor bus request (in) / grant (out), both active-low
//   dreq_                 - per-channel start request, active-low
//   dsaddr/ddaddr/dcount  - per-channel source, destination, word count (packed per channel)
//   dmode                 - per-channel mode: 00 single, 01 burst, 10 fixed-source burst, 11 illegal
//   mem_addr/mem_wdata/mem_we/mem_rdata - shared memory port (read data one cycle after address)
//   eop_                  - per-channel end-of-process, active-low one-cycle pulse
//   busy                  - per-channel armed-or-active flag
module dma_mc #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cpu_breq_,
    output logic                             cpu_bgrt_,
    input  logic [NUM_CH-1:0]                dreq_,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]     dsaddr,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]     ddaddr,
    input  logic [NUM_CH*CNT_WIDTH-1:0]      dcount,
    input  logic [NUM_CH*2-1:0]              dmode,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    output logic                             mem_we,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic [NUM_CH-1:0]                eop_,
    output logic [NUM_CH-1:0]                busy
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W:0]   NUM_CH_X = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

    localparam logic [1:0] MODE_SINGLE  = 2'b00;
    localparam logic [1:0] MODE_FIXED   = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_RD,
        S_LAT,
        S_WR,
        S_DONE
    } state_t;

    state_t state;

    // Per-channel progress; updated in place so interleaved channels resume where they left off.
    logic [ADDR_WIDTH-1:0] ch_src  [NUM_CH];
    logic [ADDR_WIDTH-1:0] ch_dst  [NUM_CH];
    logic [CNT_WIDTH-1:0]  ch_cnt  [NUM_CH];
    logic [1:0]            ch_mode [NUM_CH];

    logic [CH_W-1:0] cur_ch;
    logic [CH_W-1:0] rr_ptr;

    // Round-robin pick: first busy channel at or after rr_ptr, wrapping.
    logic [CH_W-1:0] arb_ch;
    logic            arb_found;
    logic [CH_W:0]   arb_idx;

    always_comb begin
        arb_ch    = '0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            arb_idx = {1'b0, rr_ptr} + (CH_W+1)'(k);
            if (arb_idx >= NUM_CH_X) begin
                arb_idx = arb_idx - NUM_CH_X;
            end
            if (!arb_found && busy[arb_idx[CH_W-1:0]]) begin
                arb_found = 1'b1;
                arb_ch    = arb_idx[CH_W-1:0];
            end
        end
    end

    logic [CNT_WIDTH-1:0]  arb_cnt;
    logic [1:0]            arb_mode;
    logic [ADDR_WIDTH-1:0] cur_src;
    logic [ADDR_WIDTH-1:0] cur_dst;
    logic [CNT_WIDTH-1:0]  cur_cnt;
    logic [1:0]            cur_mode;
    logic [ADDR_WIDTH-1:0] cur_src_nxt;
    logic [CH_W-1:0]       cur_next;

    assign arb_cnt     = ch_cnt[arb_ch];
    assign arb_mode    = ch_mode[arb_ch];
    assign cur_src     = ch_src[cur_ch];
    assign cur_dst     = ch_dst[cur_ch];
    assign cur_cnt     = ch_cnt[cur_ch];
    assign cur_mode    = ch_mode[cur_ch];
    // Fixed-source mode re-reads the same word; address arithmetic wraps naturally.
    assign cur_src_nxt = (cur_mode == MODE_FIXED) ? cur_src : cur_src + 1'b1;
    assign cur_next    = (cur_ch == LAST_CH) ? '0 : cur_ch + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cpu_bgrt_ <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            eop_      <= '1;
            busy      <= '0;
            rr_ptr    <= '0;
            cur_ch    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_src[i]  <= '0;
                ch_dst[i]  <= '0;
                ch_cnt[i]  <= '0;
                ch_mode[i] <= '0;
            end
        end else begin
            // Arming only touches idle channels, so it never collides with the active channel.
            for (int i = 0; i < NUM_CH; i++) begin
                if (!dreq_[i] && !busy[i]) begin
                    ch_src[i]  <= dsaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    ch_dst[i]  <= ddaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    ch_cnt[i]  <= dcount[i*CNT_WIDTH +: CNT_WIDTH];
                    ch_mode[i] <= dmode[i*2 +: 2];
                    busy[i]    <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    cpu_bgrt_ <= 1'b0;
                    if ((|busy) && cpu_breq_) begin
                        state     <= S_ARB;
                        cpu_bgrt_ <= 1'b1;
                    end
                end

                S_ARB: begin
                    cur_ch <= arb_ch;
                    if (!arb_found) begin
                        state     <= S_IDLE;
                        cpu_bgrt_ <= 1'b0;
                    end else if ((arb_cnt == '0) || (arb_mode == MODE_ILLEGAL)) begin
                        state        <= S_DONE;
                        eop_[arb_ch] <= 1'b0;
                    end else begin
                        state    <= S_RD;
                        mem_addr <= ch_src[arb_ch];
                        mem_we   <= 1'b0;
                    end
                end

                S_RD: begin
                    state <= S_LAT;
                end

                S_LAT: begin
                    mem_wdata <= mem_rdata;
                    mem_addr  <= cur_dst;
                    mem_we    <= 1'b1;
                    state     <= S_WR;
                end

                S_WR: begin
                    mem_we         <= 1'b0;
                    ch_dst[cur_ch] <= cur_dst + 1'b1;
                    ch_src[cur_ch] <= cur_src_nxt;
                    ch_cnt[cur_ch] <= cur_cnt - 1'b1;
                    if (cur_cnt == CNT_WIDTH'(1)) begin
                        state        <= S_DONE;
                        eop_[cur_ch] <= 1'b0;
                    end else if (cur_mode == MODE_SINGLE) begin
                        // Advance the pointer after each single word so other channels interleave.
                        state     <= S_IDLE;
                        cpu_bgrt_ <= 1'b0;
                        rr_ptr    <= cur_next;
                    end else begin
                        state    <= S_RD;
                        mem_addr <= cur_src_nxt;
                    end
                end

                S_DONE: begin
                    eop_[cur_ch] <= 1'b1;
                    busy[cur_ch] <= 1'b0;
                    rr_ptr       <= cur_next;
                    cpu_bgrt_    <= 1'b0;
                    state        <= S_IDLE;
                end

                default: begin
                    state     <= S_IDLE;
                    cpu_bgrt_ <= 1'b0;
                    mem_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule
